// File: rtl/mcu_mem_pkg.sv
// rtl/mcu_mem_pkg.sv - shared defaults, lane helper and FSM state type for the MCU memory subsystem
package mcu_mem_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 14;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

    localparam int DEFAULT_BE_W = byte_lanes(DEFAULT_DATA_W);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bram_state_t;

endpackage

// File: rtl/bram_clear_fsm.sv
// rtl/bram_clear_fsm.sv - clear sequencer: zeroes one word per cycle after reset or on request
module bram_clear_fsm
    import mcu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DEPTH      = 2**ADDR_W,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam bram_state_t       RST_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    bram_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clr_req is only honoured from IDLE, so a request mid-clear never restarts the count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    // Hold off the array while reset is asserted so reset never alters stored data
    assign clr_we   = busy & ~rst;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/bram_sp_be.sv
// rtl/bram_sp_be.sv - single-port block RAM with byte-lane writes, optional output register and clear engine
module bram_sp_be
    import mcu_mem_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DEPTH      = 2**ADDR_W,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                clr_req,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy
);

    localparam int              BE_W    = byte_lanes(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              in_range;
    logic              usr_we;
    logic              rd_fire;
    logic              wr_go;
    logic [ADDR_W-1:0] wr_addr;
    logic [BE_W-1:0]   wr_be;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] ram_q;
    logic              zero_q;
    logic              v1_q;
    logic [DATA_W-1:0] stage_data;

    bram_clear_fsm #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign usr_we   = en & wr_en & ~busy & in_range & ~rst;
    assign rd_fire  = en & ~wr_en & ~busy;

    // Clear engine owns the single port while busy; user accesses are ignored then
    assign wr_go   = clr_we | usr_we;
    assign wr_addr = clr_we ? clr_addr : addr;
    assign wr_be   = clr_we ? {BE_W{1'b1}} : be;
    assign wr_data = clr_we ? '0 : wdata;
    assign rd_idx  = in_range ? addr : '0;

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_fire) begin
            ram_q <= mem[rd_idx];
        end
    end

    // zero_q masks the unreset RAM output after reset and for out-of-range reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b1;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= rd_fire;
            if (rd_fire) begin
                zero_q <= ~in_range;
            end
        end
    end

    assign stage_data = zero_q ? '0 : ram_q;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rdata_q;
            logic              v2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                    v2_q    <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        rdata_q <= stage_data;
                    end
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = v2_q;
        end else begin : g_no_out_reg
            assign rdata  = stage_data;
            assign rvalid = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sp_be.sv
// tb/tb_bram_sp_be.sv - directed self-checking bench for bram_sp_be
module tb_bram_sp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_en;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        clr_req;

    logic [31:0] rdata0, rdata1, rdata2;
    logic        rvalid0, rvalid1, rvalid2;
    logic        busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    bram_sp_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .OUT_REG(0), .INIT_CLEAR(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .be(be), .addr(addr), .wdata(wdata),
        .clr_req(clr_req), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0)
    );

    bram_sp_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .OUT_REG(1), .INIT_CLEAR(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .be(be), .addr(addr), .wdata(wdata),
        .clr_req(clr_req), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
    );

    bram_sp_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .OUT_REG(0), .INIT_CLEAR(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .be(be), .addr(addr), .wdata(wdata),
        .clr_req(clr_req), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        en      = 1'b0;
        wr_en   = 1'b0;
        be      = 4'h0;
        addr    = 4'h0;
        wdata   = 32'h0;
        clr_req = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        en    = 1'b1;
        wr_en = wr;
        addr  = a;
        wdata = d;
        be    = b;
    endtask

    task automatic count_busy(input string name, input int exp_len);
        int n;
        n = 0;
        while (busy0 && n < 100) begin
            clr_req = (n == 5);
            n++;
            tick();
        end
        clr_req = 1'b0;
        check(name, 32'(n), 32'(exp_len));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0, c1, c2;
        logic [31:0] pat;

        vecs[0]  = '{1'b1, 4'd3, 32'hDEADBEEF, 4'b1111, 32'h0};
        vecs[1]  = '{1'b1, 4'd3, 32'h000000AA, 4'b0001, 32'h0};
        vecs[2]  = '{1'b0, 4'd3, 32'h0,        4'b0000, 32'hDEADBEAA};
        vecs[3]  = '{1'b1, 4'd7, 32'h11223344, 4'b1111, 32'h0};
        vecs[4]  = '{1'b1, 4'd7, 32'hAABBCCDD, 4'b1010, 32'h0};
        vecs[5]  = '{1'b0, 4'd7, 32'h0,        4'b0000, 32'hAA22CC44};
        vecs[6]  = '{1'b1, 4'd7, 32'hFFFFFFFF, 4'b0000, 32'h0};
        vecs[7]  = '{1'b0, 4'd7, 32'h0,        4'b0000, 32'hAA22CC44};
        vecs[8]  = '{1'b1, 4'd5, 32'h12345678, 4'b1111, 32'h0};
        vecs[9]  = '{1'b0, 4'd5, 32'h0,        4'b0000, 32'h12345678};
        vecs[10] = '{1'b1, 4'd1, 32'h11111111, 4'b1111, 32'h0};
        vecs[11] = '{1'b1, 4'd2, 32'h22222222, 4'b1111, 32'h0};
        vecs[12] = '{1'b0, 4'd1, 32'h0,        4'b0000, 32'h11111111};
        vecs[13] = '{1'b0, 4'd0, 32'h0,        4'b0000, 32'h00000000};

        rst = 1'b1;
        idle_in();
        tick();
        tick();
        check("rst_busy",   32'(busy0),   32'd1);
        check("rst_rvalid", 32'(rvalid0), 32'd0);
        check("rst_rdata",  rdata0,       32'h0);
        check("rst_rdata1", rdata1,       32'h0);

        rst = 1'b0;
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 20; i++) begin
            c0 += int'(busy0);
            c1 += int'(busy1);
            c2 += int'(busy2);
            tick();
        end
        check("init_busy_len_d16",  32'(c0), 32'd16);
        check("init_busy_len_or1",  32'(c1), 32'd16);
        check("init_busy_len_d12",  32'(c2), 32'd12);

        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'(a), 32'h0, 4'h0);
            tick();
            check("clr_read_rvalid", 32'(rvalid0), 32'd1);
            check("clr_read_data",   rdata0,       32'h0);
        end
        idle_in();
        tick();
        check("rvalid_drops", 32'(rvalid0), 32'd0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            tick();
            if (vecs[i].wr) begin
                check("vec_write_no_rvalid", 32'(rvalid0), 32'd0);
            end else begin
                check("vec_read_rvalid", 32'(rvalid0), 32'd1);
                check("vec_read_data",   rdata0,       vecs[i].exp);
            end
        end
        idle_in();
        tick();

        drive(1'b0, 4'd1, 32'h0, 4'h0);
        tick();
        check("or1_lat_not_yet", 32'(rvalid1), 32'd0);
        drive(1'b0, 4'd2, 32'h0, 4'h0);
        tick();
        check("or1_rvalid_a1", 32'(rvalid1), 32'd1);
        check("or1_rdata_a1",  rdata1,       32'h11111111);
        drive(1'b0, 4'd3, 32'h0, 4'h0);
        tick();
        check("or1_rvalid_a2", 32'(rvalid1), 32'd1);
        check("or1_rdata_a2",  rdata1,       32'h22222222);
        idle_in();
        tick();
        check("or1_rvalid_a3", 32'(rvalid1), 32'd1);
        check("or1_rdata_a3",  rdata1,       32'hDEADBEAA);
        tick();
        check("or1_rvalid_end", 32'(rvalid1), 32'd0);
        check("or1_rdata_hold", rdata1,       32'hDEADBEAA);

        drive(1'b0, 4'd5, 32'h0, 4'h0);
        clr_req = 1'b1;
        tick();
        idle_in();
        check("clrreq_busy",   32'(busy0),   32'd1);
        check("clrreq_rvalid", 32'(rvalid0), 32'd1);
        check("clrreq_rdata",  rdata0,       32'h12345678);
        count_busy("clrreq_busy_len", 16);
        drive(1'b0, 4'd5, 32'h0, 4'h0);
        tick();
        check("after_clr_rvalid", 32'(rvalid0), 32'd1);
        check("after_clr_rdata",  rdata0,       32'h0);

        drive(1'b1, 4'd4, 32'h0BADCAFE, 4'hF);
        tick();
        drive(1'b0, 4'd4, 32'h0, 4'h0);
        clr_req = 1'b1;
        tick();
        idle_in();
        for (int i = 0; i < 7; i++) tick();
        check("midclr_rdata_pre",  rdata0, 32'h0BADCAFE);
        check("midclr_rdata1_pre", rdata1, 32'h0BADCAFE);
        #2;
        rst = 1'b1;
        #1;
        check("midclr_rst_rdata",  rdata0,       32'h0);
        check("midclr_rst_rvalid", 32'(rvalid0), 32'd0);
        check("midclr_rst_rdata1", rdata1,       32'h0);
        check("midclr_rst_busy",   32'(busy0),   32'd1);
        tick();
        rst = 1'b0;
        count_busy("midclr_busy_len", 16);

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 4'(i), 32'h10000000 + 32'(i) * 32'h01010101, 4'hF);
            tick();
        end
        drive(1'b1, 4'd13, 32'hCAFEF00D, 4'hF);
        tick();
        drive(1'b0, 4'd13, 32'h0, 4'h0);
        tick();
        check("oor_rvalid",     32'(rvalid2), 32'd1);
        check("oor_rdata",      rdata2,       32'h0);
        check("inrange13_data", rdata0,       32'hCAFEF00D);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 4'(i), 32'h0, 4'h0);
            tick();
            pat = 32'h10000000 + 32'(i) * 32'h01010101;
            check("d12_word_rvalid", 32'(rvalid2), 32'd1);
            check("d12_word_data",   rdata2,       pat);
        end
        idle_in();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_sp_be.md
# bram_sp_be

Parametrised single-port block RAM for the MCU memory subsystem, the successor to the fixed 32x16K data RAM. Adds byte-lane write enables, a configurable read pipeline with a valid strobe, and a sequential clear engine that zeroes the array one word per cycle, after reset or on request, instead of in a single reset cycle. Sits between the bus/load-store unit and the memory array.

## Interface
- `DATA_W`, default 32: word width; must be a multiple of 8.
- `ADDR_W`, default 14: word-address width.
- `DEPTH`, default 2**ADDR_W: number of words; DEPTH ≤ 2**ADDR_W.
- `OUT_REG`, default 0: 1 adds an output register, giving read latency 2 instead of 1.
- `INIT_CLEAR`, default 1: 1 starts a clear sequence on reset release; 0 leaves contents undefined.

- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: access request this cycle.
- `wr_en`  in  1: with `en`, write; else read.
- `be`  in  DATA_W/8: byte-lane write enables; bit i covers bits 8i+7:8i.
- `addr`  in  ADDR_W: word address.
- `wdata`  in  DATA_W: write data.
- `clr_req`  in  1: pulse to start a clear sequence.
- `rdata`  out  DATA_W: read data; holds its last value between reads.
- `rvalid`  out  1: one-cycle strobe marking `rdata` valid.
- `busy`  out  1: clear sequence in progress; accesses are ignored.

## Operation
- FSM states: CLEAR and IDLE.
- Reset:
  - State goes to CLEAR if INIT_CLEAR=1, else IDLE.
  - Clear counter resets to 0.
  - `rdata`=0, `rvalid`=0, `busy`=INIT_CLEAR.
  - The pipeline is flushed.
  - The array itself is not touched by `rst`.
- CLEAR:
  - Each cycle writes 0 to word `cnt`, then increments `cnt`.
  - After writing word DEPTH-1, moves to IDLE.
  - `busy`=1 throughout.
  - `en`, `wr_en` and `clr_req` are ignored; no `rvalid` is generated.
- IDLE: `busy`=0.
  - Write (`en`=1, `wr_en`=1): each lane with `be[i]`=1 is updated; other lanes are kept.
    - `be`=0 is a legal no-op write.
  - Read (`en`=1, `wr_en`=0): returns `mem[addr]`.
    - A write never produces `rvalid`.
  - Out-of-range address (`addr` ≥ DEPTH): writes are dropped; reads return 0 and still assert `rvalid`.
  - `clr_req`=1 moves to CLEAR next cycle with `cnt`=0.
    - An access presented in the same cycle as `clr_req` is still performed.
    - Reads already issued still complete with `rvalid` during CLEAR.
- Read-during-write to the same word cannot occur (single port). Back-to-back accesses give full throughput: one access per cycle.

## Timing
- Read latency:
  - OUT_REG=0: `en` sampled at edge N gives `rdata`/`rvalid` after edge N+1 (latency 1).
  - OUT_REG=1: latency 2.
- Write takes effect at the sampling edge. A read of the same address on the next cycle returns the new data.
- Clear duration:
  - `busy` rises the cycle after `clr_req` is sampled (or at reset).
  - `busy` stays high for exactly DEPTH cycles.
  - `busy` falls after edge DEPTH; the first access is accepted at the next edge.
- `rst` asserted mid-clear or mid-read: immediate return to reset values.
  - With INIT_CLEAR=1, the clear restarts from word 0 on release.
- `clr_req` while `busy`=1: ignored; it does not restart the count.

## Structure
- Shared package `mcu_mem_pkg`:
  - Default `DATA_W`/`ADDR_W`.
  - `localparam` for the byte-lane count.
  - FSM state enum `bram_state_t` {IDLE, CLEAR}.
- Sub-module `bram_clear_fsm`:
  - Owns the state register, the `cnt` counter (ADDR_W bits, terminal count DEPTH-1) and `busy`.
  - Drives an internal write port muxed ahead of the array.
- The array and output pipeline live in the top level. Inference must give a single-port RAM with byte-write.

## Test plan
- Reset release, INIT_CLEAR=1, DEPTH=16 → `busy` high for 16 cycles; then reads of all 16 addresses return 0, each with `rvalid` exactly 1 cycle later.
- Write 0xDEADBEEF to addr 3 with `be`=4'b1111, then write 0x000000AA with `be`=4'b0001 → reading addr 3 returns 0xDEADBEAA.
- OUT_REG=1, back-to-back reads of addrs 1,2,3 → `rvalid` on cycles N+2, N+3, N+4 with the matching data, and no gaps.
- Read of addr 5 issued in the same cycle as `clr_req` → addr 5's old data returned with `rvalid` while `busy`=1; after `busy` falls, addr 5 reads 0.
- `rst` pulsed halfway through a clear → `rdata`=0 and `rvalid`=0 immediately; `busy` then stays high for a full DEPTH cycles.
- DEPTH=12, ADDR_W=4: write to addr 13 → addr 13 reads 0 with `rvalid`=1, and words 0–11 are unchanged.
